credit_push_tx: RTL and testbench

- Producer-side counterpart to the team's ready/valid FIFO when that FIFO sits across a credit-based link, e.g. a dispatch-to-issue-queue or ROB-to-commit crossing.
- Accepts entries on a ready/valid input and pushes them one per cycle into a remote FIFO of known depth.
- Tracks the remote FIFO's free space with a credit counter, so the push side never needs a ready signal.
- Supports a drain handshake so flush logic can wait until the remote FIFO is empty.

---
 rtl/credit_push_tx_pkg.sv | 9 +
 rtl/credit_counter.sv | 29 ++
 rtl/credit_push_tx.sv | 58 +++++
 tb/tb_credit_push_tx.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/credit_push_tx_pkg.sv
// credit_push_tx_pkg: shared FSM encodings and credit counter width helper
package credit_push_tx_pkg;
  localparam logic [1:0] CPT_RUN     = 2'd0;
  localparam logic [1:0] CPT_DRAIN   = 2'd1;
  localparam logic [1:0] CPT_DRAINED = 2'd2;
  function automatic int ctr_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/credit_counter.sv
// credit_counter: up/down counter saturating at INIT with sticky overflow
module credit_counter #(
  parameter int INIT  = 8,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_aH,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf
);
  logic at_max;
  logic [WIDTH-1:0] cnt_nxt;
  always_comb begin
    at_max  = cnt == WIDTH'(INIT);
    cnt_nxt = (inc && !dec && !at_max) ? cnt + 1'b1 :
              (dec && !inc)            ? cnt - 1'b1 : cnt;
  end
  always_ff @(posedge clk) begin
    if (rst_aH) begin
      cnt <= WIDTH'(INIT);
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= ovf | (inc && !dec && at_max);
    end
  end
endmodule

// File: rtl/credit_push_tx.sv
// credit_push_tx: credit-tracked push side of a remote FIFO with drain handshake
module credit_push_tx
  import credit_push_tx_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int CREDITS    = 8,
  localparam int CTR_WIDTH  = ctr_width(CREDITS)
) (
  input  logic                  clk,
  input  logic                  rst_aH,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  push_valid,
  output logic [DATA_WIDTH-1:0] push_data,
  input  logic                  credit_ret,
  input  logic                  drain_req,
  output logic                  drained,
  output logic [CTR_WIDTH-1:0]  credit_cnt,
  output logic                  credit_err
);
  logic [1:0] state, state_nxt;
  logic accept;
  assign accept = in_valid && in_ready;
  credit_counter #(.INIT(CREDITS), .WIDTH(CTR_WIDTH)) u_ctr (
    .clk   (clk),
    .rst_aH(rst_aH),
    .inc   (credit_ret),
    .dec   (accept),
    .cnt   (credit_cnt),
    .ovf   (credit_err)
  );
  always_ff @(posedge clk) begin
    if (rst_aH) begin
      state      <= CPT_RUN;
      push_valid <= 1'b0;
      push_data  <= '0;
    end else begin
      state      <= state_nxt;
      push_valid <= accept;
      push_data  <= accept ? in_data : push_data;
    end
  end
  always_comb begin
    state_nxt = CPT_RUN;
    case (state)
      CPT_RUN:     state_nxt = drain_req ? CPT_DRAIN : CPT_RUN;
      CPT_DRAIN:   state_nxt = !drain_req ? CPT_RUN :
                               (credit_cnt == CTR_WIDTH'(CREDITS) && !push_valid) ? CPT_DRAINED : CPT_DRAIN;
      CPT_DRAINED: state_nxt = drain_req ? CPT_DRAINED : CPT_RUN;
      default:     state_nxt = CPT_RUN;
    endcase
  end
  always_comb begin
    in_ready = state == CPT_RUN && credit_cnt != '0;
    drained  = state == CPT_DRAINED;
  end
endmodule

// File: tb/tb_credit_push_tx.sv
// tb_credit_push_tx: directed self-checking bench for credit_push_tx with CREDITS=4
module tb_credit_push_tx;
  logic        clk = 1'b0;
  logic        rst_aH = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        push_valid;
  logic [31:0] push_data;
  logic        credit_ret = 1'b0;
  logic        drain_req = 1'b0;
  logic        drained;
  logic [2:0]  credit_cnt;
  logic        credit_err;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] d [0:7];
  credit_push_tx #(.DATA_WIDTH(32), .CREDITS(4)) dut (
    .clk       (clk),
    .rst_aH    (rst_aH),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .push_valid(push_valid),
    .push_data (push_data),
    .credit_ret(credit_ret),
    .drain_req (drain_req),
    .drained   (drained),
    .credit_cnt(credit_cnt),
    .credit_err(credit_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 8; i++) d[i] = 32'hA000_0000 + 32'(i) * 32'h1111;
    step();
    rst_aH = 1'b0;
    chk("rst_cnt", 32'(credit_cnt), 4);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_pv", 32'(push_valid), 0);
    chk("rst_pd", push_data, 0);
    chk("rst_drained", 32'(drained), 0);
    chk("rst_err", 32'(credit_err), 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = d[i];
      step();
      chk("burst_pv", 32'(push_valid), 1);
      chk("burst_pd", push_data, d[i]);
      chk("burst_cnt", 32'(credit_cnt), 32'(3 - i));
    end
    chk("full_ready", 32'(in_ready), 0);
    in_data = d[4];
    step();
    chk("stall_pv", 32'(push_valid), 0);
    chk("stall_pd_hold", push_data, d[3]);
    chk("stall_cnt", 32'(credit_cnt), 0);
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    chk("ret1_cnt", 32'(credit_cnt), 1);
    chk("ret1_pv", 32'(push_valid), 0);
    chk("ret1_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("e_pv", 32'(push_valid), 1);
    chk("e_pd", push_data, d[4]);
    chk("e_cnt", 32'(credit_cnt), 0);
    chk("e_ready", 32'(in_ready), 0);
    credit_ret = 1'b1;
    step();
    step();
    chk("ret2_cnt", 32'(credit_cnt), 2);
    in_valid = 1'b1;
    in_data  = d[5];
    step();
    credit_ret = 1'b0;
    chk("both_pv", 32'(push_valid), 1);
    chk("both_pd", push_data, d[5]);
    chk("both_cnt", 32'(credit_cnt), 2);
    in_data = d[6];
    step();
    in_valid  = 1'b0;
    drain_req = 1'b1;
    chk("g_cnt", 32'(credit_cnt), 1);
    step();
    chk("drain_ready", 32'(in_ready), 0);
    chk("drain_drained", 32'(drained), 0);
    chk("drain_pv", 32'(push_valid), 0);
    in_valid   = 1'b1;
    in_data    = d[7];
    credit_ret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drain_ret_cnt", 32'(credit_cnt), 32'(2 + i));
      chk("drain_ret_ready", 32'(in_ready), 0);
      chk("drain_ret_drained", 32'(drained), 0);
      chk("drain_ret_pv", 32'(push_valid), 0);
    end
    credit_ret = 1'b0;
    in_valid   = 1'b0;
    step();
    chk("drained_set", 32'(drained), 1);
    chk("drained_ready", 32'(in_ready), 0);
    drain_req = 1'b0;
    step();
    chk("undrain_drained", 32'(drained), 0);
    chk("undrain_ready", 32'(in_ready), 1);
    chk("undrain_cnt", 32'(credit_cnt), 4);
    credit_ret = 1'b1;
    step();
    credit_ret = 1'b0;
    chk("ovf_err", 32'(credit_err), 1);
    chk("ovf_cnt", 32'(credit_cnt), 4);
    step();
    chk("ovf_sticky", 32'(credit_err), 1);
    in_valid = 1'b1;
    in_data  = d[1];
    step();
    chk("mid_pv", 32'(push_valid), 1);
    chk("mid_cnt", 32'(credit_cnt), 3);
    rst_aH = 1'b1;
    step();
    rst_aH   = 1'b0;
    in_valid = 1'b0;
    chk("mrst_pv", 32'(push_valid), 0);
    chk("mrst_pd", push_data, 0);
    chk("mrst_cnt", 32'(credit_cnt), 4);
    chk("mrst_err", 32'(credit_err), 0);
    chk("mrst_ready", 32'(in_ready), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
